// File: rtl/key_press_gen_if.sv
// -----------------------------------------------------------------------------
// key_press_gen_if
// Command/status bundle of the bouncy key-press generator.
//   master : requester side. Drives start/key_sel/abort and observes the key
//            lines and status.
//   slave  : generator side (key_press_gen).
// Signals:
//   start   : single-cycle press request
//   key_sel : index of the key to press
//   abort   : cancel an in-progress press
//   key_n   : active-low key lines (1 = released)
//   busy    : press sequence in progress
//   done    : one-cycle pulse on normal completion
//   err     : one-cycle pulse when start names a non-existent key
// -----------------------------------------------------------------------------
interface key_press_gen_if #(
  parameter int NUM_KEYS = 3
) ();
  localparam int SEL_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  logic                start;
  logic [SEL_W-1:0]    key_sel;
  logic                abort;
  logic [NUM_KEYS-1:0] key_n;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start, key_sel, abort,
    input  key_n, busy, done, err
  );

  modport slave (
    input  start, key_sel, abort,
    output key_n, busy, done, err
  );
endinterface

// File: rtl/key_press_gen.sv
// -----------------------------------------------------------------------------
// key_press_gen
// Produces a realistic push-button waveform on one of NUM_KEYS active-low key
// lines: a bouncy press (BOUNCE_PULSES low glitches separated by high gaps),
// a solid low hold of HOLD_CYC cycles, a bouncy release (BOUNCE_PULSES high
// glitches separated by low gaps) and a released quiet period of QUIET_CYC
// cycles before signalling done. Glitch and gap widths come from a free-running
// 16-bit Galois LFSR.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : key_press_gen_if slave modport (start, key_sel, abort in;
//           key_n, busy, done, err out). All outputs are registered.
// -----------------------------------------------------------------------------
module key_press_gen #(
  parameter int          NUM_KEYS      = 3,
  parameter int          BOUNCE_PULSES = 4,
  parameter int          BOUNCE_W      = 4,
  parameter int          HOLD_CYC      = 2000000,
  parameter int          QUIET_CYC     = 2000000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  key_press_gen_if.slave   bus
);

  localparam int SEL_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int MAX_CYC = (HOLD_CYC > QUIET_CYC) ? HOLD_CYC : QUIET_CYC;
  localparam int CYC_W   = $clog2(MAX_CYC + 1);
  // One down-counter times every phase, so it must also hold a bounce width.
  localparam int CNT_W   = (CYC_W > BOUNCE_W) ? CYC_W : BOUNCE_W;
  localparam int PC_W    = (BOUNCE_PULSES > 0) ? $clog2(BOUNCE_PULSES + 1) : 1;

  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] QUIET_LOAD = CNT_W'(QUIET_CYC - 1);
  localparam logic [PC_W-1:0]  PULSES     = PC_W'(BOUNCE_PULSES);

  // Elaboration-time parameter sanity.
  if (HOLD_CYC < 1 || QUIET_CYC < 1) begin : g_bad_cyc
    $error("key_press_gen: HOLD_CYC and QUIET_CYC must be >= 1");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("key_press_gen: LFSR_SEED must be nonzero");
  end
  if (BOUNCE_W < 1 || BOUNCE_W > 16) begin : g_bad_bw
    $error("key_press_gen: BOUNCE_W must be in 1..16");
  end
  if (BOUNCE_PULSES < 0) begin : g_bad_bp
    $error("key_press_gen: BOUNCE_PULSES must be >= 0");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_P_LOW  = 3'd1,
    S_P_HIGH = 3'd2,
    S_HOLD   = 3'd3,
    S_R_HIGH = 3'd4,
    S_R_LOW  = 3'd5,
    S_QUIET  = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PC_W-1:0]     pcnt_q, pcnt_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [NUM_KEYS-1:0] key_n_q, key_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                sel_valid;
  logic                phase_end;
  logic [PC_W-1:0]     pcnt_inc;
  logic [CNT_W-1:0]    bounce_load;
  logic                key_low;

  // Galois LFSR, x^16+x^14+x^13+x^11+1, right-shifting; free-running.
  assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

  // A new glitch/gap phase is loaded with lfsr_d, which is exactly the LFSR
  // value visible during the first cycle of that phase. The counter holds
  // width-1, so loading the raw bits gives w = bits + 1 cycles.
  assign bounce_load = CNT_W'(lfsr_d[BOUNCE_W-1:0]);

  assign sel_valid = (32'(bus.key_sel) < 32'(NUM_KEYS));
  assign phase_end = (cnt_q == '0);
  assign pcnt_inc  = pcnt_q + 1'b1;

  // State register plus datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      sel_q   <= '0;
      key_n_q <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      sel_q   <= sel_d;
      key_n_q <= key_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pcnt_d  = pcnt_q;
    cnt_d   = (state_q == S_IDLE) ? cnt_q : cnt_q - 1'b1;

    if (state_q != S_IDLE && bus.abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start && sel_valid) begin
            sel_d = bus.key_sel;
            if (BOUNCE_PULSES > 0) begin
              state_d = S_P_LOW;
              cnt_d   = bounce_load;
              pcnt_d  = '0;
            end else begin
              state_d = S_HOLD;
              cnt_d   = HOLD_LOAD;
            end
          end
        end
        S_P_LOW: begin
          if (phase_end) begin
            state_d = S_P_HIGH;
            cnt_d   = bounce_load;
          end
        end
        S_P_HIGH: begin
          if (phase_end) begin
            pcnt_d = pcnt_inc;
            if (pcnt_inc < PULSES) begin
              state_d = S_P_LOW;
              cnt_d   = bounce_load;
            end else begin
              state_d = S_HOLD;
              cnt_d   = HOLD_LOAD;
            end
          end
        end
        S_HOLD: begin
          if (phase_end) begin
            if (BOUNCE_PULSES > 0) begin
              state_d = S_R_HIGH;
              cnt_d   = bounce_load;
              pcnt_d  = '0;
            end else begin
              state_d = S_QUIET;
              cnt_d   = QUIET_LOAD;
            end
          end
        end
        S_R_HIGH: begin
          if (phase_end) begin
            state_d = S_R_LOW;
            cnt_d   = bounce_load;
          end
        end
        S_R_LOW: begin
          if (phase_end) begin
            pcnt_d = pcnt_inc;
            if (pcnt_inc < PULSES) begin
              state_d = S_R_HIGH;
              cnt_d   = bounce_load;
            end else begin
              state_d = S_QUIET;
              cnt_d   = QUIET_LOAD;
            end
          end
        end
        S_QUIET: begin
          if (phase_end) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output logic: outputs are decoded from the next state so the registered
  // key lines change in the same cycle the FSM enters a phase.
  always_comb begin
    key_low = (state_d == S_P_LOW) || (state_d == S_HOLD) || (state_d == S_R_LOW);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_q == S_QUIET) && phase_end && !bus.abort;
    err_d   = (state_q == S_IDLE) && bus.start && !sel_valid;
  end

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    assign key_n_d[gi] = ~(key_low && (sel_d == SEL_W'(gi)));
  end

  assign bus.key_n = key_n_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_key_press_gen.sv
// -----------------------------------------------------------------------------
// tb_key_press_gen
// Two generator instances share clk/rst_n: dut_c has clean edges
// (BOUNCE_PULSES=0, HOLD 10, QUIET 5); dut_b bounces (4 pulses, BOUNCE_W=2,
// HOLD 20, QUIET 8). Expected per-cycle {key_n, busy, done, err} tuples are
// generated from a waveform model and a free-running reference LFSR, pushed
// to a queue when a press is launched and popped one per clock afterwards.
// -----------------------------------------------------------------------------
module tb_key_press_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  key_press_gen_if #(.NUM_KEYS(3)) if_c ();
  key_press_gen_if #(.NUM_KEYS(3)) if_b ();

  key_press_gen #(
    .NUM_KEYS(3), .BOUNCE_PULSES(0), .BOUNCE_W(4),
    .HOLD_CYC(10), .QUIET_CYC(5), .LFSR_SEED(16'hACE1)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c)
  );

  key_press_gen #(
    .NUM_KEYS(3), .BOUNCE_PULSES(4), .BOUNCE_W(2),
    .HOLD_CYC(20), .QUIET_CYC(8), .LFSR_SEED(16'hACE1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b)
  );

  wire [5:0] obs_c = {if_c.key_n, if_c.busy, if_c.done, if_c.err};
  wire [5:0] obs_b = {if_b.key_n, if_b.busy, if_b.done, if_b.err};

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic [5:0]  exp_q[$];

  // Reference LFSR: x^16+x^14+x^13+x^11+1 Galois form, seed ACE1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_step(m_lfsr);
  end

  // Push n busy cycles at a given level on key sel; l tracks the LFSR value
  // of each cycle so the next phase draws its width from its own first cycle.
  task automatic push_level(input int n, input bit low, input int sel,
                            inout logic [15:0] l);
    logic [2:0] kv;
    for (int i = 0; i < n; i++) begin
      kv = 3'b111;
      if (low) kv[sel] = 1'b0;
      exp_q.push_back({kv, 3'b100});
      l = lfsr_step(l);
    end
  endtask

  // Whole press waveform, starting the cycle after start is sampled.
  // Call while m_lfsr holds the value of the start-sampling cycle.
  task automatic push_press(input int bp, input int bmask, input int hold,
                            input int quiet, input int sel);
    logic [15:0] l;
    int w;
    l = lfsr_step(m_lfsr);
    for (int p = 0; p < bp; p++) begin
      w = (int'(l) & bmask) + 1; push_level(w, 1'b1, sel, l);
      w = (int'(l) & bmask) + 1; push_level(w, 1'b0, sel, l);
    end
    push_level(hold, 1'b1, sel, l);
    for (int p = 0; p < bp; p++) begin
      w = (int'(l) & bmask) + 1; push_level(w, 1'b0, sel, l);
      w = (int'(l) & bmask) + 1; push_level(w, 1'b1, sel, l);
    end
    push_level(quiet, 1'b0, sel, l);
    exp_q.push_back(6'b111_010);   // done cycle, busy already low
    exp_q.push_back(6'b111_000);   // done is a single pulse
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_assert++;
    if (obs_c !== 6'b111_000) begin
      n_fail++; $display("FAIL reset_c got %b want %b", obs_c, 6'b111_000);
    end
    n_assert++;
    if (obs_b !== 6'b111_000) begin
      n_fail++; $display("FAIL reset_b got %b want %b", obs_b, 6'b111_000);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_assert++;
    if (obs_b !== 6'b111_000) begin
      n_fail++; $display("FAIL post_reset_b got %b want %b", obs_b, 6'b111_000);
    end
  endtask

  task automatic test_clean_press();
    int it = 0;
    logic [5:0] e;
    @(negedge clk);
    if_c.start = 1'b1; if_c.key_sel = 2'd1;
    push_press(0, 0, 10, 5, 1);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      // start while busy (valid and invalid key) must be ignored
      if_c.start   = (it == 3 || it == 4);
      if_c.key_sel = (it == 3) ? 2'd0 : (it == 4) ? 2'd3 : 2'd1;
      e = exp_q.pop_front();
      n_assert++;
      if (obs_c !== e) begin
        n_fail++; $display("FAIL clean_press cyc%0d got %b want %b", it + 1, obs_c, e);
      end
      it++;
    end
  endtask

  task automatic test_invalid_sel();
    @(negedge clk);
    if_c.start = 1'b1; if_c.key_sel = 2'd3;
    if_b.start = 1'b1; if_b.key_sel = 2'd3;
    @(posedge clk); #1;
    if_c.start = 1'b0; if_b.start = 1'b0;
    n_assert++;
    if (obs_c !== 6'b111_001) begin
      n_fail++; $display("FAIL invalid_err_c got %b want %b", obs_c, 6'b111_001);
    end
    n_assert++;
    if (obs_b !== 6'b111_001) begin
      n_fail++; $display("FAIL invalid_err_b got %b want %b", obs_b, 6'b111_001);
    end
    @(posedge clk); #1;
    n_assert++;
    if (obs_c !== 6'b111_000) begin
      n_fail++; $display("FAIL invalid_pulse_c got %b want %b", obs_c, 6'b111_000);
    end
    n_assert++;
    if (obs_b !== 6'b111_000) begin
      n_fail++; $display("FAIL invalid_pulse_b got %b want %b", obs_b, 6'b111_000);
    end
  endtask

  task automatic test_bouncy_press(input string tag, input int sel);
    int it = 0;
    logic [5:0] e;
    @(negedge clk);
    if_b.start = 1'b1; if_b.key_sel = 2'(sel);
    push_press(4, 3, 20, 8, sel);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      if_b.start = 1'b0;
      e = exp_q.pop_front();
      n_assert++;
      if (obs_b !== e) begin
        n_fail++; $display("FAIL %s cyc%0d got %b want %b", tag, it + 1, obs_b, e);
      end
      it++;
    end
  endtask

  task automatic test_abort();
    int it = 0;
    logic [5:0] e;
    @(negedge clk);
    if_c.start = 1'b1; if_c.key_sel = 2'd2;
    @(posedge clk); #1;
    if_c.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    if (obs_c !== 6'b011_100) begin
      n_fail++; $display("FAIL abort_in_hold got %b want %b", obs_c, 6'b011_100);
    end
    if_c.abort = 1'b1;
    @(posedge clk); #1;
    if_c.abort = 1'b0;
    n_assert++;
    if (obs_c !== 6'b111_000) begin
      n_fail++; $display("FAIL abort_next got %b want %b", obs_c, 6'b111_000);
    end
    // no done may follow an aborted press
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n_assert++;
      if (obs_c !== 6'b111_000) begin
        n_fail++; $display("FAIL abort_quiet cyc%0d got %b want %b", i, obs_c, 6'b111_000);
      end
    end
    // abort in IDLE has no effect
    if_c.abort = 1'b1;
    @(posedge clk); #1;
    if_c.abort = 1'b0;
    n_assert++;
    if (obs_c !== 6'b111_000) begin
      n_fail++; $display("FAIL abort_idle got %b want %b", obs_c, 6'b111_000);
    end
    // start together with abort in IDLE is accepted and runs a full press
    @(negedge clk);
    if_c.start = 1'b1; if_c.abort = 1'b1; if_c.key_sel = 2'd0;
    push_press(0, 0, 10, 5, 0);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      if_c.start = 1'b0; if_c.abort = 1'b0;
      e = exp_q.pop_front();
      n_assert++;
      if (obs_c !== e) begin
        n_fail++; $display("FAIL press_after_abort cyc%0d got %b want %b", it + 1, obs_c, e);
      end
      it++;
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    if_b.start = 1'b1; if_b.key_sel = 2'd0;
    @(posedge clk); #1;
    if_b.start = 1'b0;
    n_assert++;
    if (obs_b !== 6'b110_100) begin
      n_fail++; $display("FAIL p_low_entry got %b want %b", obs_b, 6'b110_100);
    end
    #1 rst_n = 1'b0;
    #1;
    n_assert++;
    if (obs_b !== 6'b111_000) begin
      n_fail++; $display("FAIL async_reset got %b want %b", obs_b, 6'b111_000);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_assert++;
    if (obs_b !== 6'b111_000) begin
      n_fail++; $display("FAIL no_done_after_reset got %b want %b", obs_b, 6'b111_000);
    end
    // reloaded LFSR: press again, checked against the reseeded model
    test_bouncy_press("press_after_reset", 1);
  endtask

  initial begin
    if_c.start = 1'b0; if_c.key_sel = '0; if_c.abort = 1'b0;
    if_b.start = 1'b0; if_b.key_sel = '0; if_b.abort = 1'b0;
    test_reset();
    test_clean_press();
    test_invalid_sel();
    test_bouncy_press("bouncy_press", 2);
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired, time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
